// File: rtl/ip_reg_pkg.sv
// Shared types and constants for the register-bus arbiter.
//   arb_state_e            : arbiter FSM state encoding
//   REG_TIMEOUT_DATA       : read data returned when the slave never answers
//   REG_TIMEOUT_CYCLES_DEF : default slave-ack timeout in clock cycles
//   GRANT_ID_W             : width of requester indices (up to 8 requesters)
package ip_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic [31:0] REG_TIMEOUT_DATA       = 32'hDEAD_BEEF;
  localparam int          REG_TIMEOUT_CYCLES_DEF = 255;
  localparam int          GRANT_ID_W             = 3;

endpackage

// File: rtl/ip_rr_arbiter.sv
// Combinational round-robin pick.
//   req_i     : request vector, one bit per requester
//   ptr_i     : requester with highest priority this round (must be < NUM_REQ)
//   gnt_o     : one-hot grant
//   gnt_idx_o : index of the granted requester
//   gnt_vld_o : at least one request present
module ip_rr_arbiter
  import ip_reg_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [GRANT_ID_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [GRANT_ID_W-1:0] gnt_idx_o,
  output logic                  gnt_vld_o
);

  logic [2*NUM_REQ-1:0]  dbl;
  logic [NUM_REQ-1:0]    rot;
  logic [GRANT_ID_W-1:0] pos;
  logic [GRANT_ID_W:0]   idx_sum;

  always_comb begin
    // Rotate so the pointer position sits at bit 0, then take the lowest set bit.
    dbl       = {req_i, req_i} >> ptr_i;
    rot       = dbl[NUM_REQ-1:0];
    pos       = '0;
    gnt_o     = '0;
    gnt_vld_o = |rot;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) pos = GRANT_ID_W'(k);
    end
    idx_sum = {1'b0, ptr_i} + {1'b0, pos};
    if (idx_sum >= (GRANT_ID_W + 1)'(NUM_REQ)) idx_sum = idx_sum - (GRANT_ID_W + 1)'(NUM_REQ);
    gnt_idx_o = idx_sum[GRANT_ID_W-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = gnt_vld_o && (gnt_idx_o == GRANT_ID_W'(i));
    end
  end

endmodule

// File: rtl/ip_reg_arbiter.sv
// Register-bus arbiter: NUM_REQ masters share one slave, one transaction at a time.
//   clock, reset                    : clock, synchronous active-high reset
//   registerSelectM/ReadM/AddressM/WriteDataM : per-requester command (32-bit packed fields)
//   registerAckM, registerErrorM, registerReadDataM : response to the granted requester
//   registerSelectS/ReadS/AddressS/WriteDataS : command to the shared slave
//   registerAckS, registerErrorS, registerReadDataS : slave response
//   grantId                         : current or last granted requester
// Optional feature: define IP_REG_ARB_TIMEOUT_EN to build the slave-ack timeout
// (TIMEOUT_CYCLES BUSY cycles, then error ack with REG_TIMEOUT_DATA).
//
// state | meaning
// IDLE  | no transaction; pick a requester round-robin from rr_ptr
// BUSY  | slave select high, waiting for slave ack (or timeout)
// DONE  | ack issued; wait for the granted requester to drop its select
module ip_reg_arbiter
  import ip_reg_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = REG_TIMEOUT_CYCLES_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      registerSelectM,
  input  logic [NUM_REQ-1:0]      registerReadM,
  input  logic [NUM_REQ*32-1:0]   registerAddressM,
  input  logic [NUM_REQ*32-1:0]   registerWriteDataM,
  output logic [NUM_REQ-1:0]      registerAckM,
  output logic                    registerErrorM,
  output logic [31:0]             registerReadDataM,
  output logic                    registerSelectS,
  output logic                    registerReadS,
  output logic [31:0]             registerAddressS,
  output logic [31:0]             registerWriteDataS,
  input  logic                    registerAckS,
  input  logic                    registerErrorS,
  input  logic [31:0]             registerReadDataS,
  output logic [GRANT_ID_W-1:0]   grantId
);

  arb_state_e            state_q, state_d;
  logic [GRANT_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_ID_W-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0]    gnt_oh_q, gnt_oh_d;
  logic                  sel_s_q, sel_s_d;
  logic                  read_s_q, read_s_d;
  logic [31:0]           addr_s_q, addr_s_d;
  logic [31:0]           wdata_s_q, wdata_s_d;
  logic [NUM_REQ-1:0]    ack_m_q, ack_m_d;
  logic                  err_m_q, err_m_d;
  logic [31:0]           rdata_m_q, rdata_m_d;
  logic                  timeout_hit;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [GRANT_ID_W-1:0] arb_idx;
  logic                  arb_vld;

  ip_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i     (registerSelectM),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

`ifdef IP_REG_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counter holds the number of completed BUSY cycles; the last allowed cycle has cnt_q = TIMEOUT_CYCLES-1.
  assign timeout_hit = (state_q == ST_BUSY) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign cnt_d       = (state_q == ST_BUSY && !registerAckS && !timeout_hit) ? cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // The timeout length is only consumed when the counter is built.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    gnt_oh_d  = gnt_oh_q;
    sel_s_d   = sel_s_q;
    read_s_d  = read_s_q;
    addr_s_d  = addr_s_q;
    wdata_s_d = wdata_s_q;
    ack_m_d   = '0;
    err_m_d   = err_m_q;
    rdata_m_d = rdata_m_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_d  = arb_idx;
          gnt_oh_d = arb_gnt;
          sel_s_d  = 1'b1;
          state_d  = ST_BUSY;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
              read_s_d  = registerReadM[i];
              addr_s_d  = registerAddressM[32*i +: 32];
              wdata_s_d = registerWriteDataM[32*i +: 32];
            end
          end
        end
      end
      ST_BUSY: begin
        if (registerAckS || timeout_hit) begin
          sel_s_d = 1'b0;
          ack_m_d = gnt_oh_q;
          state_d = ST_DONE;
          // A slave ack coinciding with the timeout still delivers the real response.
          if (registerAckS) begin
            err_m_d   = registerErrorS;
            rdata_m_d = registerReadDataS;
          end else begin
            err_m_d   = 1'b1;
            rdata_m_d = REG_TIMEOUT_DATA;
          end
        end
      end
      ST_DONE: begin
        if ((registerSelectM & gnt_oh_q) == '0) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == GRANT_ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      gnt_oh_q  <= '0;
      sel_s_q   <= 1'b0;
      read_s_q  <= 1'b0;
      addr_s_q  <= '0;
      wdata_s_q <= '0;
      ack_m_q   <= '0;
      err_m_q   <= 1'b0;
      rdata_m_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      gnt_oh_q  <= gnt_oh_d;
      sel_s_q   <= sel_s_d;
      read_s_q  <= read_s_d;
      addr_s_q  <= addr_s_d;
      wdata_s_q <= wdata_s_d;
      ack_m_q   <= ack_m_d;
      err_m_q   <= err_m_d;
      rdata_m_q <= rdata_m_d;
    end
  end

  assign registerAckM       = ack_m_q;
  assign registerErrorM     = err_m_q;
  assign registerReadDataM  = rdata_m_q;
  assign registerSelectS    = sel_s_q;
  assign registerReadS      = read_s_q;
  assign registerAddressS   = addr_s_q;
  assign registerWriteDataS = wdata_s_q;
  assign grantId            = grant_q;

endmodule
